adc_interface: RTL and testbench



---
 rtl/adc_interface.sv | 200 ++++++++++++++++++++
 tb/tb_adc_interface.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_interface.sv
// ADC128S022 serial controller: frame timing, DIN address shifting, DOUT capture
// and push-button selection of five acquisition modes.
`timescale 1ns/1ps
module adc_interface (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dout,
    input  logic        mode_input,
    input  logic [2:0]  channel_in,
    output logic        cs_n,
    output logic        sclk,
    output logic        din,
    output logic        cnv,
    output logic [11:0] data,
    output logic [11:0] display,
    output logic        clk_xk,
    output logic [3:0]  address,
    output logic [3:0]  sclk_count,
    output logic [9:0]  count,
    output logic        mode_count,
    output logic [2:0]  mode,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        M_IDLE    = 3'd0,
        M_SINGLE  = 3'd1,
        M_CONT    = 3'd2,
        M_SCAN    = 3'd3,
        M_ONESHOT = 3'd4
    } mode_t;

    state_t      state_q;
    mode_t       mode_q, mode_d, frame_mode_q;
    logic        btn_s1_q, btn_s2_q, btn_prev_q, press;
    logic        mode_count_q;
    logic [9:0]  count_q, cnt_nxt;
    logic        clk_xk_q;
    logic        cs_n_q, sclk_q, din_q, cnv_q;
    logic [3:0]  sclk_count_q, address_q, frames_left_q;
    logic [2:0]  scan_q, prev_addr_q, addr_sel;
    logic [11:0] cap_q, data_q, display_q;
    logic        frame_req, start_frame, in_frame_d, in_shift_win, sample, din_d;
    logic [8:0]  rel;
    logic [3:0]  period_k;

    assign press   = btn_prev_q & ~btn_s2_q;
    assign cnt_nxt = (count_q == 10'd999) ? '0 : count_q + 10'd1;

    always_comb begin
        mode_d = M_IDLE;
        case (mode_q)
            M_IDLE:   mode_d = M_SINGLE;
            M_SINGLE: mode_d = M_CONT;
            M_CONT:   mode_d = M_SCAN;
            M_SCAN:   mode_d = M_ONESHOT;
            default:  mode_d = M_IDLE;
        endcase
    end

    always_comb begin
        frame_req = 1'b0;
        case (mode_q)
            M_SINGLE, M_ONESHOT: frame_req = (frames_left_q != 4'd0);
            M_CONT, M_SCAN:      frame_req = 1'b1;
            default:             frame_req = 1'b0;
        endcase
    end

    assign addr_sel = (mode_q == M_SCAN || mode_q == M_ONESHOT) ? scan_q : channel_in;

    // All frame outputs are decoded from the next count so the registered
    // values line up exactly with the count value they belong to.
    assign start_frame  = (state_q == ST_IDLE || state_q == ST_WAIT) &&
                          (cnt_nxt == 10'd0) && frame_req;
    assign in_frame_d   = start_frame ||
                          ((state_q == ST_START || state_q == ST_SHIFT) && cnt_nxt != 10'd544);
    assign in_shift_win = in_frame_d && (cnt_nxt >= 10'd16) && (cnt_nxt <= 10'd527);
    assign rel          = cnt_nxt[8:0] - 9'd16;
    assign period_k     = rel[8:5];
    assign sample       = in_shift_win && (rel[4:0] == 5'd16) && (period_k >= 4'd4);

    always_comb begin
        din_d = 1'b0;
        if (in_shift_win) begin
            case (period_k)
                4'd2:    din_d = address_q[2];
                4'd3:    din_d = address_q[1];
                4'd4:    din_d = address_q[0];
                default: din_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q      <= 1'b1;
            btn_s2_q      <= 1'b1;
            btn_prev_q    <= 1'b1;
            mode_count_q  <= 1'b0;
            mode_q        <= M_IDLE;
            frame_mode_q  <= M_IDLE;
            state_q       <= ST_IDLE;
            count_q       <= '0;
            clk_xk_q      <= 1'b0;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b1;
            din_q         <= 1'b0;
            cnv_q         <= 1'b0;
            sclk_count_q  <= '0;
            address_q     <= '0;
            prev_addr_q   <= '0;
            scan_q        <= '0;
            frames_left_q <= '0;
            cap_q         <= '0;
            data_q        <= '0;
            display_q     <= '0;
        end else begin
            btn_s1_q     <= mode_input;
            btn_s2_q     <= btn_s1_q;
            btn_prev_q   <= btn_s2_q;
            mode_count_q <= press;

            count_q      <= cnt_nxt;
            clk_xk_q     <= (cnt_nxt < 10'd500);
            cs_n_q       <= ~in_frame_d;
            sclk_q       <= ~(in_shift_win && !rel[4]);
            din_q        <= din_d;
            sclk_count_q <= (in_frame_d && cnt_nxt >= 10'd16) ? period_k : 4'd0;
            cnv_q        <= (state_q == ST_SHIFT) && (cnt_nxt == 10'd544);

            if (sample)
                cap_q <= {cap_q[10:0], dout};

            if (start_frame) begin
                address_q    <= {1'b0, addr_sel};
                prev_addr_q  <= address_q[2:0];
                frame_mode_q <= mode_q;
                if (mode_q == M_SCAN || mode_q == M_ONESHOT)
                    scan_q <= scan_q + 3'd1;
                if (mode_q == M_SINGLE || mode_q == M_ONESHOT)
                    frames_left_q <= frames_left_q - 4'd1;
            end

            // A press restarts the per-mode bookkeeping; the running frame is untouched.
            if (press) begin
                mode_q <= mode_d;
                scan_q <= '0;
                if (mode_d == M_SINGLE)
                    frames_left_q <= 4'd2;
                else if (mode_d == M_ONESHOT)
                    frames_left_q <= 4'd9;
                else
                    frames_left_q <= 4'd0;
            end

            case (state_q)
                ST_IDLE:  if (start_frame) state_q <= ST_START;
                ST_START: if (cnt_nxt == 10'd16) state_q <= ST_SHIFT;
                ST_SHIFT: if (cnt_nxt == 10'd544) state_q <= ST_DONE;
                ST_DONE:  state_q <= ST_WAIT;
                ST_WAIT:  if (cnt_nxt == 10'd0) state_q <= start_frame ? ST_START : ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase

            if (state_q == ST_DONE) begin
                data_q <= cap_q;
                if (frame_mode_q == M_SCAN || frame_mode_q == M_ONESHOT) begin
                    if (prev_addr_q == channel_in)
                        display_q <= cap_q;
                end else begin
                    display_q <= cap_q;
                end
            end
        end
    end

    assign cs_n       = cs_n_q;
    assign sclk       = sclk_q;
    assign din        = din_q;
    assign cnv        = cnv_q;
    assign data       = data_q;
    assign display    = display_q;
    assign clk_xk     = clk_xk_q;
    assign address    = address_q;
    assign sclk_count = sclk_count_q;
    assign count      = count_q;
    assign mode_count = mode_count_q;
    assign mode       = mode_q;
    assign state      = state_q;

endmodule

// File: tb/tb_adc_interface.sv
// Bench for adc_interface: ADC128S022 behavioural model on the serial pins and a
// scoreboard of expected per-frame results.
`timescale 1ns/1ps
module tb_adc_interface;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dout = 1'b0;
    logic        mode_input = 1'b1;
    logic [2:0]  channel_in = 3'd2;
    logic        cs_n, sclk, din, cnv, clk_xk, mode_count;
    logic [11:0] data, display;
    logic [3:0]  address, sclk_count;
    logic [9:0]  count;
    logic [2:0]  mode, state;

    adc_interface dut (
        .clk(clk), .rst_n(rst_n), .dout(dout), .mode_input(mode_input),
        .channel_in(channel_in), .cs_n(cs_n), .sclk(sclk), .din(din), .cnv(cnv),
        .data(data), .display(display), .clk_xk(clk_xk), .address(address),
        .sclk_count(sclk_count), .count(count), .mode_count(mode_count),
        .mode(mode), .state(state)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        logic [11:0] disp;
        logic [3:0]  a;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] chan_val [8] = '{12'h3C1, 12'h7E2, 12'hA5C, 12'h123,
                                  12'h456, 12'h789, 12'hBCD, 12'hEF0};
    int          checks = 0;
    int          errors = 0;
    int          tb_mode = 0;
    int          scan_idx = 0;
    logic [2:0]  model_prev = 3'd0;
    logic [11:0] last_disp = 12'd0;
    logic [2:0]  pred_addr = 3'd0;
    logic [2:0]  adc_prev = 3'd0;
    logic [2:0]  dec = 3'd0;
    logic [11:0] word = 12'd0;
    int          falls = 0, rises = 0, low = 0;
    int          cnv_cnt = 0, frames = 0, mc_cnt = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, pend = 1'b0;
    exp_t        e_push, e_pop;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ADC model plus frame-level protocol checks; expected results pushed at frame start.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_cs && !cs_n) begin
                frames++;
                low = 0; rises = 0; falls = 0; dec = 3'd0;
                word = chan_val[adc_prev];
                pred_addr = (tb_mode == 3 || tb_mode == 4) ? scan_idx[2:0] : channel_in;
                e_push.d = chan_val[model_prev];
                if (tb_mode == 3 || tb_mode == 4) begin
                    scan_idx = (scan_idx + 1) % 8;
                    e_push.disp = (model_prev == channel_in) ? e_push.d : last_disp;
                end else begin
                    e_push.disp = e_push.d;
                end
                e_push.a = {1'b0, pred_addr};
                last_disp = e_push.disp;
                model_prev = pred_addr;
                sb.push_back(e_push);
            end
            if (!cs_n) low++;
            if (!cs_n && !prev_sclk && sclk) begin
                if (rises >= 2 && rises <= 4) dec = {dec[1:0], din};
                rises++;
            end
            if (!cs_n && prev_sclk && !sclk) begin
                dout = (falls >= 4 && falls <= 15) ? word[15 - falls] : 1'b0;
                falls++;
            end
            if (!prev_cs && cs_n) begin
                check("cs_low_cycles", low, 544);
                check("sclk_rises", rises, 16);
                check("din_addr", dec, pred_addr);
                adc_prev = dec;
            end
            if (mode_count) mc_cnt++;
            prev_cs = cs_n;
            prev_sclk = sclk;
        end
    end

    // Scoreboard monitor: results are checked the cycle after each cnv pulse.
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_result actual=unexpected_cnv expected=no_cnv");
            end else begin
                e_pop = sb.pop_front();
                check("sb_data", data, e_pop.d);
                check("sb_display", display, e_pop.disp);
                check("sb_address", address, e_pop.a);
            end
        end
        if (rst_n && cnv) begin
            cnv_cnt++;
            pend = 1'b1;
        end
    end

    task automatic wait_count(input int v);
        int n = 0;
        while (count !== v[9:0] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("wait_count_timeout", 1, 0);
    endtask

    task automatic press(input int next, input bit mid);
        int c0;
        int n = 0;
        if (mid) begin
            while (!(cs_n === 1'b0 && sclk_count === 4'd5) && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 3000) check("wait_midframe_timeout", 1, 0);
        end else begin
            wait_count(600);
        end
        c0 = mc_cnt;
        mode_input = 1'b0;
        repeat (10) @(negedge clk);
        mode_input = 1'b1;
        tb_mode = next;
        if (next == 3 || next == 4) scan_idx = 0;
        repeat (5) @(negedge clk);
        check("mode_pulse", mc_cnt - c0, 1);
        check("mode_value", mode, next);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, xh, csl, sl;
        repeat (5) @(negedge clk);
        check("reset_outputs",
              {cs_n, sclk, din, cnv, data, display, clk_xk, address, sclk_count,
               count, mode_count, mode, state},
              {2'b11, 52'd0});
        rst_n = 1'b1;
        xh = 0; csl = 0; sl = 0;
        repeat (2000) begin
            @(negedge clk);
            if (clk_xk) xh++;
            if (!cs_n) csl++;
            if (!sclk) sl++;
        end
        check("clk_xk_high_cycles", xh, 1000);
        check("idle_cs_low", csl, 0);
        check("idle_sclk_low", sl, 0);
        check("idle_mode", mode, 0);
        check("idle_state", state, 0);
        wait_count(999);
        @(negedge clk);
        check("count_wrap", count, 0);

        press(1, 1'b0);
        c = cnv_cnt;
        repeat (4000) @(negedge clk);
        check("single_frames", cnv_cnt - c, 2);
        check("single_data", data, 12'hA5C);
        check("single_display", display, 12'hA5C);
        check("single_state_idle", state, 0);

        press(2, 1'b0);
        c = cnv_cnt;
        repeat (3000) @(negedge clk);
        check("cont_frames", cnv_cnt - c, 3);

        press(3, 1'b1);
        wait_count(600);
        c = cnv_cnt;
        repeat (12000) @(negedge clk);
        check("scan_frames", cnv_cnt - c, 12);

        press(4, 1'b0);
        c = cnv_cnt;
        repeat (11000) @(negedge clk);
        check("oneshot_frames", cnv_cnt - c, 9);
        check("oneshot_state_idle", state, 0);

        press(0, 1'b0);
        c = cnv_cnt;
        repeat (3000) @(negedge clk);
        check("idle_frames", cnv_cnt - c, 0);
        check("idle_cs_n", cs_n, 1);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
